tlatch_driver: RTL and testbench

Sequencer that sits directly upstream of the T latch and drives its `t` and `en` inputs. On a start request it issues a programmed number of single-cycle toggle pulses with a fixed gap between them. After the sequence it samples the latch output back and checks that the latch ended in the expected parity state. It replaces hand-written stimulus with a reusable, self-checking driver stage.

---
 rtl/tlatch_pkg.sv | 14 +
 rtl/tlatch_driver_sync2.sv | 25 ++
 rtl/tlatch_driver.sv | 143 ++++++++++++++
 tb/tb_tlatch_driver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlatch_pkg.sv
// Shared constants for the T-latch driver.
// State encoding and settle length.
package tlatch_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int SETTLE_CYC = 2;

endpackage

// File: rtl/tlatch_driver_sync2.sv
// Two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, i_d (async in), o_q (synced out).
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_m;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m <= 1'b0;
      r_q <= 1'b0;
    end else begin
      r_m <= i_d;
      r_q <= r_m;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tlatch_driver.sv
// Toggle-pulse sequencer for a T latch with parity self-check.
// Ports: clk, reset(n), start, count in; t, en, busy, done, mismatch, toggles_done out.
module tlatch_driver
  import tlatch_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             q_in,
  output logic             t,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] toggles_done
);

  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  localparam logic [1:0] SET_LAST = 2'(SETTLE_CYC - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_tog;
  logic [3:0]       r_gap;
  logic [1:0]       r_settle;
  logic             r_exp_q;
  logic             r_mis;
  logic             r_t;
  logic             r_en;
  logic             r_busy;
  logic             r_done;
  logic             w_q_s;
  logic             w_go;
  logic             w_gap_last;
  logic             w_set_last;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (reset),
    .i_d   (q_in),
    .o_q   (w_q_s)
  );

  assign w_go       = (r_state == S_IDLE) && start;
  assign w_gap_last = (r_gap == GAP_LAST);
  assign w_set_last = (r_settle == SET_LAST);

  always_comb begin
    w_nxt = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        if (start)
          w_nxt = (count == '0) ? S_DONE : S_ARM;
      end
      (r_state == S_ARM):   w_nxt = S_PULSE;
      (r_state == S_PULSE): w_nxt = S_WAIT;
      (r_state == S_WAIT): begin
        if (w_gap_last)
          w_nxt = (r_tog == r_count) ? S_SETTLE : S_PULSE;
      end
      (r_state == S_SETTLE): begin
        if (w_set_last)
          w_nxt = S_DONE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tog   <= '0;
    end else if (w_go) begin
      r_count <= count;
      r_tog   <= '0;
    end else if (r_state == S_PULSE) begin
      r_tog   <= r_tog + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap    <= '0;
      r_settle <= '0;
    end else begin
      r_gap    <= (r_state == S_WAIT) ? r_gap + 4'd1 : 4'd0;
      r_settle <= (r_state == S_SETTLE) ? r_settle + 2'd1 : 2'd0;
    end
  end

  // exp_q tracks what the latch should read after each pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_exp_q <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      if (r_state == S_ARM)
        r_exp_q <= w_q_s;
      else if (r_state == S_PULSE)
        r_exp_q <= ~r_exp_q;
      if (w_go)
        r_mis <= 1'b0;
      else if (r_state == S_SETTLE && w_set_last)
        r_mis <= w_q_s ^ r_exp_q;
    end
  end

  // Outputs decoded from next state so they are glitch-free flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_t    <= 1'b0;
      r_en   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_t    <= (w_nxt == S_PULSE);
      r_en   <= (w_nxt == S_PULSE);
      r_busy <= (w_nxt != S_IDLE);
      r_done <= (w_nxt == S_DONE);
    end
  end

  assign t            = r_t;
  assign en           = r_en;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mismatch     = r_mis;
  assign toggles_done = r_tog;

endmodule

// File: tb/tb_tlatch_driver.sv
// Scoreboard bench for tlatch_driver with a T-latch model.
// Random sequences, reset, sticky mismatch, back-to-back, 255 pulses.
module tb_tlatch_driver;

  localparam int G  = 2;
  localparam int G1 = 1;

  typedef struct {
    int n;
    int sc;
    bit mis;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] count = 8'd0;
  logic       q_in;
  logic       t, en, busy, done, mismatch;
  logic [7:0] toggles_done;
  logic       lq = 1'b0;
  logic       force0 = 1'b0;

  logic       start1 = 1'b0;
  logic [7:0] count1 = 8'd0;
  logic       t1, en1, busy1, done1, mis1;
  logic [7:0] tog1;
  logic       lq1 = 1'b0;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pk = 0;
  int   p1 = 0;
  bit   prev_en = 1'b0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  assign q_in = force0 ? 1'b0 : lq;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (en && t) lq <= ~lq;
  always @(posedge clk) if (en1 && t1) lq1 <= ~lq1;
  always @(negedge clk) if (en1) p1 <= p1 + 1;

  tlatch_driver #(.CNT_W(8), .GAP(G)) u_dut (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start),
    .count        (count),
    .q_in         (q_in),
    .t            (t),
    .en           (en),
    .busy         (busy),
    .done         (done),
    .mismatch     (mismatch),
    .toggles_done (toggles_done)
  );

  tlatch_driver #(.CNT_W(8), .GAP(G1)) u_dut1 (
    .clk          (clk),
    .reset        (rst_n),
    .start        (start1),
    .count        (count1),
    .q_in         (lq1),
    .t            (t1),
    .en           (en1),
    .busy         (busy1),
    .done         (done1),
    .mismatch     (mis1),
    .toggles_done (tog1)
  );

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  function automatic int lat(int n, int g);
    return (n == 0) ? 1 : 4 + n * (1 + g);
  endfunction

  // Monitor: checks every pulse position and every done against the queue head
  always @(negedge clk) begin
    if (!rst_n) begin
      pk = 0;
      prev_en = 1'b0;
    end else begin
      if (en) begin
        if (sb.size() == 0) begin
          flag("en_unexpected");
        end else begin
          pk++;
          chk("pulse_t", int'(t), 1);
          chk("pulse_cyc", cyc - sb[0].sc + 1, 2 + (pk - 1) * (1 + G));
          chk("pulse_single", int'(prev_en), 0);
        end
      end else if (t) begin
        flag("t_without_en");
      end
      prev_en = en;
      if (done) begin
        if (sb.size() == 0) begin
          flag("done_unexpected");
        end else begin
          e = sb.pop_front();
          chk("done_latency", cyc - e.sc + 1, lat(e.n, G));
          chk("toggles_done", int'(toggles_done), e.n);
          chk("mismatch", int'(mismatch), int'(e.mis));
          chk("pulse_count", pk, e.n);
          chk("busy_in_done", int'(busy), 1);
          pk = 0;
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (busy) flag("timeout_idle");
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) flag("timeout_drain");
  endtask

  task automatic push(int n, bit f);
    exp_t x;
    x.n   = n;
    x.sc  = cyc + 1;
    x.mis = f && (n % 2 == 1);
    sb.push_back(x);
  endtask

  task automatic issue(int n, bit f);
    if (force0 != f) begin
      force0 = f;
      repeat (3) @(negedge clk);
    end
    wait_idle();
    start = 1'b1;
    count = 8'(n);
    push(n, f);
    @(negedge clk);
    start = 1'b0;
    count = 8'($urandom);
  endtask

  task automatic poke();
    int k = 0;
    while (busy && k < 3000) begin
      start = 1'($urandom_range(0, 1));
      count = 8'($urandom);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (busy) flag("timeout_poke");
  endtask

  initial begin
    int last;
    int base;
    int s;
    int k;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_t", int'(t), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mis", int'(mismatch), 0);
    chk("rst_tog", int'(toggles_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(3, 1'b0);
    drain();
    issue(0, 1'b0);
    drain();

    issue(1, 1'b1);
    drain();
    repeat (3) @(negedge clk);
    chk("mis_sticky", int'(mismatch), 1);
    issue(2, 1'b0);
    chk("mis_clear", int'(mismatch), 0);
    drain();

    issue(3, 1'b0);
    k = 0;
    while (!en && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!en) flag("timeout_pulse");
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_t", int'(t), 0);
    chk("mid_rst_en", int'(en), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_mis", int'(mismatch), 0);
    chk("mid_rst_tog", int'(toggles_done), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(0, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    issue(1, 1'b0);
    drain();

    wait_idle();
    start = 1'b1;
    count = 8'd2;
    last = 0;
    for (int i = 0; i < 3; i++) begin
      wait_idle();
      if (i > 0) chk("b2b_gap", cyc + 1 - last, lat(2, G) + 1);
      last = cyc + 1;
      push(2, 1'b0);
      @(negedge clk);
    end
    start = 1'b0;
    drain();

    for (int i = 0; i < 24; i++) begin
      issue($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
      poke();
    end
    drain();

    repeat (3) @(negedge clk);
    base = p1;
    start1 = 1'b1;
    count1 = 8'hFF;
    s = cyc + 1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (!done1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (!done1) begin
      flag("timeout_ff");
    end else begin
      chk("ff_latency", cyc - s + 1, 4 + 255 * (1 + G1));
      chk("ff_toggles", int'(tog1), 255);
      chk("ff_mis", int'(mis1), 0);
      chk("ff_pulses", p1 - base, 255);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
